al_accel_requant_unit: RTL

- Requantization stage directly upstream of al_accel_act_func_unit.
- Takes 32-bit signed MAC accumulator results, adds bias, applies an integer scale and an arithmetic right shift, adds an output zero-point, then saturates to int8.
- Output act_func_do_q feeds act_func_di of the activation unit. The activation type travels as aligned sideband and feeds act_func_typ.
- 3-stage valid/ready pipeline with global stall and a saturation event counter.

---
 rtl/al_accel_requant_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/al_accel_requant_unit.sv
// Requantizer feeding the activation unit: bias add, unsigned scale, arithmetic shift, zero-point, int8 clip.
// 3-cycle latency, global stall on enb=0 or blocked output; AL_ACCEL_REQUANT_ROUND_EN selects round-half-up over floor.
module al_accel_requant_unit #(
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enb,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   acc_di,
  input  logic signed [ACC_W-1:0]   bias,
  input  logic        [SCALE_W-1:0] scale,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic signed [OUT_W-1:0]   zero_point,
  input  logic        [2:0]         typ_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   act_func_do_q,
  output logic        [2:0]         typ_o,
  output logic        [CNT_W-1:0]   sat_cnt
);

  localparam int SUM_W  = ACC_W + 1;
  localparam int PROD_W = ACC_W + SCALE_W + 2;
  localparam logic signed [PROD_W-1:0] Y_MAX = PROD_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] Y_MIN = -Y_MAX - PROD_W'(1);

  // Per-beat controls that ride alongside the data through the pipe.
  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic [OUT_W-1:0]   zp;
    logic [2:0]         typ;
  } side_t;

  logic                      adv;
  logic                      fire_in;
  logic                      v1, v2, v3;
  logic signed [SUM_W-1:0]   sum_c, sum1;
  logic        [SCALE_W-1:0] scale1;
  side_t                     side_c, side1, side2;
  logic signed [PROD_W-1:0]  prod_c, prod2;
  logic signed [PROD_W-1:0]  sh_c, y_c;
  logic signed [OUT_W-1:0]   q_c;
  logic                      clip_c;

  assign adv       = enb & (~v3 | out_ready);
  assign in_ready  = adv & ~reset;
  assign fire_in   = in_valid & in_ready;
  assign out_valid = v3;

  assign sum_c  = SUM_W'(acc_di) + SUM_W'(bias);
  assign side_c = '{shift: shift, zp: zero_point, typ: typ_i};

  // Zero-extended scale keeps the product signed without any overflow in PROD_W bits.
  assign prod_c = PROD_W'(sum1) * PROD_W'($signed({1'b0, scale1}));

`ifdef AL_ACCEL_REQUANT_ROUND_EN
  logic signed [PROD_W-1:0] rnd_c;
  assign rnd_c = (side2.shift != '0) ? (PROD_W'(1) << (side2.shift - SHIFT_W'(1))) : '0;
  assign sh_c  = (prod2 + rnd_c) >>> side2.shift;
`else
  assign sh_c  = prod2 >>> side2.shift;
`endif

  assign y_c = sh_c + PROD_W'($signed(side2.zp));

  always_comb begin
    q_c    = y_c[OUT_W-1:0];
    clip_c = 1'b0;
    if (y_c > Y_MAX) begin
      q_c    = Y_MAX[OUT_W-1:0];
      clip_c = 1'b1;
    end else if (y_c < Y_MIN) begin
      q_c    = Y_MIN[OUT_W-1:0];
      clip_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      sum1          <= '0;
      scale1        <= '0;
      side1         <= '0;
      side2         <= '0;
      prod2         <= '0;
      act_func_do_q <= '0;
      typ_o         <= '0;
      sat_cnt       <= '0;
    end else if (adv) begin
      v1     <= fire_in;
      sum1   <= sum_c;
      scale1 <= scale;
      side1  <= side_c;

      v2    <= v1;
      prod2 <= prod_c;
      side2 <= side1;

      v3 <= v2;
      // Output holds its last beat across bubbles.
      if (v2) begin
        act_func_do_q <= q_c;
        typ_o         <= side2.typ;
        if (clip_c && (sat_cnt != '1)) begin
          sat_cnt <= sat_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
